// File: rtl/rv32i_pkg.sv
// RV32I decode constants: opcodes, ALU and result-source encodings, immediate formats.
// Shared by decode_stage and reg_file.
package rv32i_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_XOR   = 4'b0100;
    localparam logic [3:0] ALU_SLT   = 4'b0101;
    localparam logic [3:0] ALU_SLTU  = 4'b0110;
    localparam logic [3:0] ALU_SLL   = 4'b0111;
    localparam logic [3:0] ALU_SRL   = 4'b1000;
    localparam logic [3:0] ALU_SRA   = 4'b1001;
    localparam logic [3:0] ALU_PASSB = 4'b1010;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_src_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // funct7[5] selects SUB only for register-register ops; it selects SRA for both shift forms.
    function automatic logic [3:0] alu_decode(input logic [2:0] funct3,
                                              input logic       funct7_b5,
                                              input logic       is_reg);
        logic [3:0] op;
        case (funct3)
            3'b000:  op = (is_reg && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two combinational reads, one write, async clear, x0 hard-wired to zero.
// Optional W->D bypass on the read ports when REGFILE_BYPASS_EN is defined.
module reg_file
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2
);

    logic [WIDTH-1:0] regs [NREG];

    // Storage update; x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            regs[wa] <= wd;
        end
    end

    // Read ports, with the same-cycle writeback forwarded only in the bypass build.
    always_comb begin
        rd1 = '0;
        rd2 = '0;
`ifdef REGFILE_BYPASS_EN
        if (ra1 == '0) begin
            rd1 = '0;
        end else if (we && (wa == ra1)) begin
            rd1 = wd;
        end else begin
            rd1 = regs[ra1];
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else if (we && (wa == ra2)) begin
            rd2 = wd;
        end else begin
            rd2 = regs[ra2];
        end
`else
        if (ra1 == '0) begin
            rd1 = '0;
        end else begin
            rd1 = regs[ra1];
        end
        if (ra2 == '0) begin
            rd2 = '0;
        end else begin
            rd2 = regs[ra2];
        end
`endif
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: IF/ID register, register file, control decoder and immediate extender.
// Build option REGFILE_BYPASS_EN forwards the writeback result to same-cycle register reads.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      InstrF_i,
    input  logic [WIDTH-1:0] PCF_i,
    input  logic [WIDTH-1:0] PCPlus4F_i,
    input  logic             StallD_i,
    input  logic             FlushD_i,
    input  logic             RegWriteW_i,
    input  logic [AW-1:0]    RdW_i,
    input  logic [WIDTH-1:0] ResultW_i,
    output logic [WIDTH-1:0] RD1D_o,
    output logic [WIDTH-1:0] RD2D_o,
    output logic [31:0]      ImmExtD_o,
    output logic [WIDTH-1:0] PCD_o,
    output logic [WIDTH-1:0] PCPlus4D_o,
    output logic [AW-1:0]    Rs1D_o,
    output logic [AW-1:0]    Rs2D_o,
    output logic [AW-1:0]    RdD_o,
    output logic             RegWriteD_o,
    output logic [1:0]       ResultSrcD_o,
    output logic             MemWriteD_o,
    output logic             BranchD_o,
    output logic             JumpD_o,
    output logic             JalrD_o,
    output logic             ALUSrcD_o,
    output logic [3:0]       ALUControlD_o,
    output logic [2:0]       Funct3D_o,
    output logic             IllegalD_o
);

    logic [31:0]      instr_d;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_plus4_d;
    imm_src_t         imm_src;
    logic [6:0]       opcode;
    logic [2:0]       funct3;
    logic             funct7_b5;

    // IF/ID register: flush beats stall; both reset and flush load a NOP bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (FlushD_i) begin
            instr_d    <= NOP_INSTR;
            pc_d       <= '0;
            pc_plus4_d <= '0;
        end else if (!StallD_i) begin
            instr_d    <= InstrF_i;
            pc_d       <= PCF_i;
            pc_plus4_d <= PCPlus4F_i;
        end
    end

    assign opcode    = instr_d[6:0];
    assign funct3    = instr_d[14:12];
    assign funct7_b5 = instr_d[30];

    assign Rs1D_o     = instr_d[15 +: AW];
    assign Rs2D_o     = instr_d[20 +: AW];
    assign RdD_o      = instr_d[7 +: AW];
    assign Funct3D_o  = funct3;
    assign PCD_o      = pc_d;
    assign PCPlus4D_o = pc_plus4_d;

    // Main and ALU control decode; JALR is reported on its own line so fetch can pick the ALU target.
    always_comb begin
        RegWriteD_o   = 1'b0;
        ResultSrcD_o  = RES_ALU;
        MemWriteD_o   = 1'b0;
        BranchD_o     = 1'b0;
        JumpD_o       = 1'b0;
        JalrD_o       = 1'b0;
        ALUSrcD_o     = 1'b0;
        ALUControlD_o = ALU_ADD;
        IllegalD_o    = 1'b0;
        imm_src       = IMM_I;
        case (opcode)
            OP_R: begin
                RegWriteD_o   = 1'b1;
                ALUControlD_o = alu_decode(funct3, funct7_b5, 1'b1);
            end
            OP_IMM: begin
                RegWriteD_o   = 1'b1;
                ALUSrcD_o     = 1'b1;
                ALUControlD_o = alu_decode(funct3, funct7_b5, 1'b0);
            end
            OP_LOAD: begin
                RegWriteD_o  = 1'b1;
                ResultSrcD_o = RES_MEM;
                ALUSrcD_o    = 1'b1;
            end
            OP_STORE: begin
                MemWriteD_o = 1'b1;
                ALUSrcD_o   = 1'b1;
                imm_src     = IMM_S;
            end
            OP_BRANCH: begin
                BranchD_o     = 1'b1;
                ALUControlD_o = ALU_SUB;
                imm_src       = IMM_B;
            end
            OP_JAL: begin
                RegWriteD_o  = 1'b1;
                ResultSrcD_o = RES_PC4;
                JumpD_o      = 1'b1;
                imm_src      = IMM_J;
            end
            OP_JALR: begin
                RegWriteD_o  = 1'b1;
                ResultSrcD_o = RES_PC4;
                JalrD_o      = 1'b1;
                ALUSrcD_o    = 1'b1;
            end
            OP_LUI: begin
                RegWriteD_o   = 1'b1;
                ALUSrcD_o     = 1'b1;
                ALUControlD_o = ALU_PASSB;
                imm_src       = IMM_U;
            end
            OP_AUIPC: begin
                RegWriteD_o = 1'b1;
                ALUSrcD_o   = 1'b1;
                imm_src     = IMM_U;
            end
            default: begin
                IllegalD_o = 1'b1;
            end
        endcase
    end

    // Immediate extender.
    always_comb begin
        ImmExtD_o = 32'h0000_0000;
        case (imm_src)
            IMM_I:   ImmExtD_o = {{20{instr_d[31]}}, instr_d[31:20]};
            IMM_S:   ImmExtD_o = {{20{instr_d[31]}}, instr_d[31:25], instr_d[11:7]};
            IMM_B:   ImmExtD_o = {{19{instr_d[31]}}, instr_d[31], instr_d[7],
                                  instr_d[30:25], instr_d[11:8], 1'b0};
            IMM_U:   ImmExtD_o = {instr_d[31:12], 12'h000};
            IMM_J:   ImmExtD_o = {{11{instr_d[31]}}, instr_d[31], instr_d[19:12],
                                  instr_d[20], instr_d[30:21], 1'b0};
            default: ImmExtD_o = 32'h0000_0000;
        endcase
    end

    reg_file #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_reg_file (
        .clk (clk),
        .rst (rst),
        .we  (RegWriteW_i),
        .wa  (RdW_i),
        .wd  (ResultW_i),
        .ra1 (instr_d[15 +: AW]),
        .ra2 (instr_d[20 +: AW]),
        .rd1 (RD1D_o),
        .rd2 (RD2D_o)
    );

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: table-driven decode vectors through a scoreboard queue,
// plus hand-written reset, stall/flush, writeback and async-reset sequences.
module tb_decode_stage;

    logic        clk;
    logic        rst;
    logic [31:0] InstrF_i, PCF_i, PCPlus4F_i;
    logic        StallD_i, FlushD_i;
    logic        RegWriteW_i;
    logic [4:0]  RdW_i;
    logic [31:0] ResultW_i;
    logic [31:0] RD1D_o, RD2D_o, ImmExtD_o, PCD_o, PCPlus4D_o;
    logic [4:0]  Rs1D_o, Rs2D_o, RdD_o;
    logic        RegWriteD_o;
    logic [1:0]  ResultSrcD_o;
    logic        MemWriteD_o, BranchD_o, JumpD_o, JalrD_o, ALUSrcD_o;
    logic [3:0]  ALUControlD_o;
    logic [2:0]  Funct3D_o;
    logic        IllegalD_o;

    int total = 0;
    int bad   = 0;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .InstrF_i      (InstrF_i),
        .PCF_i         (PCF_i),
        .PCPlus4F_i    (PCPlus4F_i),
        .StallD_i      (StallD_i),
        .FlushD_i      (FlushD_i),
        .RegWriteW_i   (RegWriteW_i),
        .RdW_i         (RdW_i),
        .ResultW_i     (ResultW_i),
        .RD1D_o        (RD1D_o),
        .RD2D_o        (RD2D_o),
        .ImmExtD_o     (ImmExtD_o),
        .PCD_o         (PCD_o),
        .PCPlus4D_o    (PCPlus4D_o),
        .Rs1D_o        (Rs1D_o),
        .Rs2D_o        (Rs2D_o),
        .RdD_o         (RdD_o),
        .RegWriteD_o   (RegWriteD_o),
        .ResultSrcD_o  (ResultSrcD_o),
        .MemWriteD_o   (MemWriteD_o),
        .BranchD_o     (BranchD_o),
        .JumpD_o       (JumpD_o),
        .JalrD_o       (JalrD_o),
        .ALUSrcD_o     (ALUSrcD_o),
        .ALUControlD_o (ALUControlD_o),
        .Funct3D_o     (Funct3D_o),
        .IllegalD_o    (IllegalD_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        chk_imm;
        logic [31:0] imm;
        logic [12:0] ctrl;   // {regwrite, resultsrc, memwrite, branch, jump, jalr, alusrc, alu, illegal}
        logic [31:0] pc;
    } vec_t;

    vec_t vecs [15];
    vec_t sb [$];

    function automatic vec_t mk(input logic [31:0] instr, input logic [4:0] rd,
                                input logic [31:0] rd1, input logic [31:0] rd2,
                                input logic chk_imm, input logic [31:0] imm,
                                input logic rw, input logic [1:0] rs, input logic mw,
                                input logic br, input logic jp, input logic jr,
                                input logic as, input logic [3:0] alu, input logic ill);
        vec_t v;
        v.instr   = instr;
        v.rd      = rd;
        v.rd1     = rd1;
        v.rd2     = rd2;
        v.chk_imm = chk_imm;
        v.imm     = imm;
        v.ctrl    = {rw, rs, mw, br, jp, jr, as, alu, ill};
        v.pc      = 32'h0;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] val);
        RegWriteW_i = 1'b1;
        RdW_i       = rd;
        ResultW_i   = val;
        @(posedge clk); #1;
        RegWriteW_i = 1'b0;
    endtask

    logic [12:0] act_ctrl;
    assign act_ctrl = {RegWriteD_o, ResultSrcD_o, MemWriteD_o, BranchD_o, JumpD_o, JalrD_o,
                       ALUSrcD_o, ALUControlD_o, IllegalD_o};

    initial begin
        vec_t e;
        // instr, rd, rd1, rd2, chk_imm, imm, rw, rs, mw, br, jp, jr, as, alu, ill  (x1=5 x2=7 x4=0x55)
        vecs[0]  = mk(32'h002081B3, 5'd3,  32'd5,  32'd7,  1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b0);
        vecs[1]  = mk(32'hFE000EE3, 5'd29, 32'd0,  32'd0,  1'b1, 32'hFFFFFFFC, 1'b0, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        vecs[2]  = mk(32'h001000EF, 5'd1,  32'd0,  32'd5,  1'b1, 32'h00000800, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 1'b0);
        vecs[3]  = mk(32'hFFF08293, 5'd5,  32'd5,  32'd0,  1'b1, 32'hFFFFFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        vecs[4]  = mk(32'h40325313, 5'd6,  32'h55, 32'd0,  1'b1, 32'h00000403, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1001, 1'b0);
        vecs[5]  = mk(32'h401103B3, 5'd7,  32'd7,  32'd5,  1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0001, 1'b0);
        vecs[6]  = mk(32'h00C0A403, 5'd8,  32'd5,  32'd0,  1'b1, 32'h0000000C, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        vecs[7]  = mk(32'hFE20AC23, 5'd24, 32'd5,  32'd7,  1'b1, 32'hFFFFFFF8, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        vecs[8]  = mk(32'h123454B7, 5'd9,  32'd0,  32'd0,  1'b1, 32'h12345000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1010, 1'b0);
        vecs[9]  = mk(32'hFFFFF517, 5'd10, 32'd0,  32'd0,  1'b1, 32'hFFFFF000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b0);
        vecs[10] = mk(32'h004100E7, 5'd1,  32'd7,  32'h55, 1'b1, 32'h00000004, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000, 1'b0);
        vecs[11] = mk(32'h0020A5B3, 5'd11, 32'd5,  32'd7,  1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0101, 1'b0);
        vecs[12] = mk(32'h0020F633, 5'd12, 32'd5,  32'd7,  1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0);
        vecs[13] = mk(32'h0020E6B3, 5'd13, 32'd5,  32'd7,  1'b0, 32'h0,        1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0011, 1'b0);
        vecs[14] = mk(32'h0000007F, 5'd0,  32'd0,  32'd0,  1'b0, 32'h0,        1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 1'b1);

        rst = 1'b1; InstrF_i = 32'hFFFFFFFF; PCF_i = 32'hDEADBEE0; PCPlus4F_i = 32'hDEADBEE4;
        StallD_i = 1'b0; FlushD_i = 1'b0; RegWriteW_i = 1'b0; RdW_i = 5'd0; ResultW_i = 32'h0;

        // Reset: NOP decode, zeroed register reads
        repeat (2) @(posedge clk);
        #1;
        check("rst_ctrl", {51'h0, act_ctrl}, {51'h0, 13'b1_00_0_0_0_0_1_0000_0});
        check("rst_rd", {59'h0, RdD_o}, 64'h0);
        check("rst_rdata", {RD1D_o, RD2D_o}, 64'h0);
        check("rst_imm_pc", {ImmExtD_o, PCD_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;

        wb(5'd1, 32'd5);
        wb(5'd2, 32'd7);
        wb(5'd4, 32'h55);

        // Decode table through the scoreboard
        for (int i = 0; i < 15; i++) begin
            InstrF_i   = vecs[i].instr;
            PCF_i      = 32'h100 + 32'(4 * i);
            PCPlus4F_i = PCF_i + 32'd4;
            e    = vecs[i];
            e.pc = PCF_i;
            sb.push_back(e);
            @(posedge clk); #1;
            if (sb.size() == 0) begin
                check($sformatf("v%0d_sb_empty", i), 64'd0, 64'd1);
            end else begin
                e = sb.pop_front();
                check($sformatf("v%0d_ctrl", i), {51'h0, act_ctrl}, {51'h0, e.ctrl});
                check($sformatf("v%0d_rdata", i), {RD1D_o, RD2D_o}, {e.rd1, e.rd2});
                check($sformatf("v%0d_rd_pc", i), {27'h0, RdD_o, PCD_o}, {27'h0, e.rd, e.pc});
                check($sformatf("v%0d_pc4", i), {32'h0, PCPlus4D_o}, {32'h0, e.pc + 32'd4});
                if (e.chk_imm) begin
                    check($sformatf("v%0d_imm", i), {32'h0, ImmExtD_o}, {32'h0, e.imm});
                end
            end
        end

        // Stall holds D while fetch advances; flush overrides stall
        InstrF_i = 32'h002081B3; PCF_i = 32'h200; PCPlus4F_i = 32'h204;
        @(posedge clk); #1;
        StallD_i = 1'b1; InstrF_i = 32'h0000007F; PCF_i = 32'h300; PCPlus4F_i = 32'h304;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            check($sformatf("stall%0d_data", c), {RD1D_o, RD2D_o}, {32'd5, 32'd7});
            check($sformatf("stall%0d_rd_pc", c), {27'h0, RdD_o, PCD_o}, {27'h0, 5'd3, 32'h200});
            check($sformatf("stall%0d_illegal", c), {63'h0, IllegalD_o}, 64'h0);
        end
        FlushD_i = 1'b1;
        @(posedge clk); #1;
        check("flush_ctrl", {51'h0, act_ctrl}, {51'h0, 13'b1_00_0_0_0_0_1_0000_0});
        check("flush_rd_pc", {27'h0, RdD_o, PCD_o}, 64'h0);
        check("flush_imm", {32'h0, ImmExtD_o}, 64'h0);

        // Writeback to x0 is dropped, including in the same cycle
        FlushD_i = 1'b0; StallD_i = 1'b0; InstrF_i = 32'h00000013; PCF_i = 32'h400; PCPlus4F_i = 32'h404;
        RegWriteW_i = 1'b1; RdW_i = 5'd0; ResultW_i = 32'h1234;
        #1;
        check("x0_same_cycle", {RD1D_o, RD2D_o}, 64'h0);
        @(posedge clk); #1;
        RegWriteW_i = 1'b0;
        check("x0_after", {RD1D_o, RD2D_o}, 64'h0);

        // Same-cycle writeback to a register being read
        InstrF_i = 32'h00020013;
        @(posedge clk); #1;
        check("x4_before", {32'h0, RD1D_o}, {32'h0, 32'h55});
        RegWriteW_i = 1'b1; RdW_i = 5'd4; ResultW_i = 32'h1234;
        #1;
`ifdef REGFILE_BYPASS_EN
        check("x4_same_cycle", {32'h0, RD1D_o}, {32'h0, 32'h1234});
`else
        check("x4_same_cycle", {32'h0, RD1D_o}, {32'h0, 32'h55});
`endif
        @(posedge clk); #1;
        RegWriteW_i = 1'b0;
        check("x4_after", {32'h0, RD1D_o}, {32'h0, 32'h1234});

        // Asynchronous reset mid-cycle clears IF/ID and the register file without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", {32'h0, PCD_o}, 64'h0);
        check("async_rst_rs1", {59'h0, Rs1D_o}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        InstrF_i = 32'h00020013;
        @(posedge clk); #1;
        check("async_rst_x4", {32'h0, RD1D_o}, 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
